// File: rtl/houghlines_accel_mul_arbiter.sv
// Round-robin share of one pipelined multiplier between NUM_REQ requesters.
// A {valid,id} shadow pipeline tracks the multiplier so each product leaves tagged.
module houghlines_accel_mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int A_W         = 10,
    parameter int B_W         = 9,
    parameter int P_W         = 19,
    parameter int MUL_LATENCY = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [P_W-1:0]         rsp_p,
    output logic                   mul_ce,
    output logic [A_W-1:0]         mul_din0,
    output logic [B_W-1:0]         mul_din1,
    input  logic [P_W-1:0]         mul_dout,
    output logic                   busy
);

    logic [MUL_LATENCY-1:0] sh_v;
    logic [ID_W-1:0]        sh_id [MUL_LATENCY];
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        rr_nxt;
    logic                   grant_any;
    logic [ID_W-1:0]        grant_id;

    assign rsp_valid = sh_v[MUL_LATENCY-1];
    assign rsp_id    = sh_id[MUL_LATENCY-1];
    assign rsp_p     = mul_dout;
    assign busy      = |sh_v;

    // A held response freezes the whole multiplier pipeline.
    assign mul_ce = ~rsp_valid | rsp_ready;

    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
        grant_any = grant_any & mul_ce;
    end

    always_comb begin
        req_ready = '0;
        mul_din0  = '0;
        mul_din1  = '0;
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
            mul_din0 = req_a[int'(grant_id)*A_W +: A_W];
            mul_din1 = req_b[int'(grant_id)*B_W +: B_W];
        end
    end

    assign rr_nxt = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_v   <= '0;
            rr_ptr <= '0;
        end else if (mul_ce) begin
            sh_v[0] <= grant_any;
            for (int k = 1; k < MUL_LATENCY; k++) begin
                sh_v[k] <= sh_v[k-1];
            end
            if (grant_any) begin
                rr_ptr <= rr_nxt;
            end
        end
    end

    // IDs are masked by sh_v, so they need no reset.
    always_ff @(posedge clk) begin
        if (mul_ce) begin
            sh_id[0] <= grant_id;
            for (int k = 1; k < MUL_LATENCY; k++) begin
                sh_id[k] <= sh_id[k-1];
            end
        end
    end

endmodule

// File: tb/tb_houghlines_accel_mul_arbiter.sv
// Directed bench for houghlines_accel_mul_arbiter with a 3-stage multiplier model.
module tb_houghlines_accel_mul_arbiter;

    localparam int NR  = 4;
    localparam int IW  = 2;
    localparam int AW  = 10;
    localparam int BW  = 9;
    localparam int PW  = 19;
    localparam int LAT = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*AW-1:0] req_a;
    logic [NR*BW-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IW-1:0]    rsp_id;
    logic [PW-1:0]    rsp_p;
    logic             mul_ce;
    logic [AW-1:0]    mul_din0;
    logic [BW-1:0]    mul_din1;
    logic [PW-1:0]    mul_dout;
    logic             busy;

    int n_asrt = 0;
    int n_fail = 0;
    int t2_prod [4] = '{200, 231, 264, 299};
    int nxt;
    int expi;

    always #5 clk = ~clk;

    houghlines_accel_mul_arbiter #(
        .NUM_REQ(NR), .ID_W(IW), .A_W(AW),
        .B_W(BW), .P_W(PW), .MUL_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_p(rsp_p),
        .mul_ce(mul_ce), .mul_din0(mul_din0),
        .mul_din1(mul_din1), .mul_dout(mul_dout),
        .busy(busy)
    );

    logic [PW-1:0] mp [LAT];
    always @(posedge clk) begin
        if (mul_ce) begin
            mp[0] <= PW'(mul_din0) * PW'(mul_din1);
            mp[1] <= mp[0];
            mp[2] <= mp[1];
        end
    end
    assign mul_dout = mp[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*AW +: AW] = AW'(a);
        req_b[i*BW +: BW] = BW'(b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_ready", 32'(req_ready), 0);

        // single request from requester 2
        set_op(2, 1000, 300);
        req_valid = 4'b0100;
        #1;
        chk("t1_ready", 32'(req_ready), 4);
        chk("t1_din0", 32'(mul_din0), 1000);
        chk("t1_din1", 32'(mul_din1), 300);
        cyc();
        req_valid = '0;
        #1;
        chk("t1_ready_drop", 32'(req_ready), 0);
        chk("t1_busy_a", 32'(busy), 1);
        chk("t1_nv_a", 32'(rsp_valid), 0);
        cyc();
        #1;
        chk("t1_busy_b", 32'(busy), 1);
        chk("t1_nv_b", 32'(rsp_valid), 0);
        cyc();
        #1;
        chk("t1_valid", 32'(rsp_valid), 1);
        chk("t1_id", 32'(rsp_id), 2);
        chk("t1_p", 32'(rsp_p), 300000);
        cyc();
        #1;
        chk("t1_done_valid", 32'(rsp_valid), 0);
        chk("t1_done_busy", 32'(busy), 0);

        // fairness with all requesters valid
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < NR; i++) set_op(i, 10 + i, 20 + i);
        for (int k = 0; k < 11; k++) begin
            req_valid = (k < 8) ? 4'hF : 4'h0;
            #1;
            chk("t2_grant", 32'(req_ready), (k < 8) ? 32'(1 << (k % 4)) : 0);
            if (k >= 3) begin
                chk("t2_valid", 32'(rsp_valid), 1);
                chk("t2_id", 32'(rsp_id), 32'((k - 3) % 4));
                chk("t2_p", 32'(rsp_p), 32'(t2_prod[(k - 3) % 4]));
            end else begin
                chk("t2_nv", 32'(rsp_valid), 0);
            end
            cyc();
        end
        #1;
        chk("t2_end_valid", 32'(rsp_valid), 0);
        chk("t2_end_busy", 32'(busy), 0);

        // stream from requester 1 with back-pressure
        nxt = 1;
        expi = 1;
        for (int w = 0; w < 20; w++) begin
            rsp_ready = !(w >= 5 && w < 10);
            if (nxt <= 8) begin
                set_op(1, nxt, 2 * nxt);
                req_valid = 4'b0010;
            end else begin
                req_valid = '0;
            end
            #1;
            if (!rsp_ready) begin
                chk("t3_stall_ce", 32'(mul_ce), 0);
                chk("t3_stall_ready", 32'(req_ready), 0);
                chk("t3_stall_valid", 32'(rsp_valid), 1);
                chk("t3_hold_p", 32'(rsp_p), 32'(expi * 2 * expi));
            end else if (rsp_valid) begin
                chk("t3_id", 32'(rsp_id), 1);
                chk("t3_p", 32'(rsp_p), 32'(expi * 2 * expi));
                expi++;
            end
            if (req_ready[1]) nxt++;
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        chk("t3_count", 32'(expi), 9);
        chk("t3_busy", 32'(busy), 0);

        // maximum operands, granted by wrap-around to requester 0
        set_op(0, 1023, 511);
        req_valid = 4'b0001;
        #1;
        chk("t4_ready", 32'(req_ready), 1);
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        #1;
        chk("t4_valid", 32'(rsp_valid), 1);
        chk("t4_id", 32'(rsp_id), 0);
        chk("t4_p", 32'(rsp_p), 522753);
        cyc();

        // sparse traffic: requester 3 then requester 0
        set_op(3, 7, 9);
        req_valid = 4'b1000;
        #1;
        chk("t5_r3", 32'(req_ready), 8);
        cyc();
        set_op(0, 5, 6);
        req_valid = 4'b0001;
        #1;
        chk("t5_r0", 32'(req_ready), 1);
        cyc();
        req_valid = '0;
        #1;
        chk("t5_bubble", 32'(rsp_valid), 0);
        cyc();
        #1;
        chk("t5_v3", 32'(rsp_valid), 1);
        chk("t5_id3", 32'(rsp_id), 3);
        chk("t5_p3", 32'(rsp_p), 63);
        cyc();
        #1;
        chk("t5_id0", 32'(rsp_id), 0);
        chk("t5_p0", 32'(rsp_p), 30);
        cyc();
        #1;
        chk("t5_tail", 32'(rsp_valid), 0);
        chk("t5_busy", 32'(busy), 0);

        // reset with three operations in flight
        req_valid = 4'hF;
        #1;
        chk("t6_g1", 32'(req_ready), 2);
        cyc();
        #1;
        chk("t6_g2", 32'(req_ready), 4);
        cyc();
        #1;
        chk("t6_g3", 32'(req_ready), 8);
        cyc();
        req_valid = '0;
        reset = 1'b1;
        #1;
        chk("t6_inflight", 32'(rsp_valid), 1);
        cyc();
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(rsp_valid), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            #1;
            chk("t6_no_stale", 32'(rsp_valid), 0);
        end
        set_op(0, 33, 3);
        req_valid = 4'hF;
        #1;
        chk("t6_rr_restart", 32'(req_ready), 1);
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        #1;
        chk("t6_valid", 32'(rsp_valid), 1);
        chk("t6_id", 32'(rsp_id), 0);
        chk("t6_p", 32'(rsp_p), 99);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
